mem_arbiter: RTL and testbench

- Shares one single-port, ack-based memory bus between instruction fetch (driven by the pc register's pc/ce) and the MEM-stage load/store unit.
- Issues registered bus requests and returns read data to each side.
- Raises per-side stall requests to the pipeline controller until the side's access completes.
- Holds a completed result while the pipeline is stalled, and aborts on flush.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store bus arbiter.
// Holds the arbiter state encoding and bus defaults.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_GNT_IF   = 3'd1,
    ARB_GNT_MEM  = 3'd2,
    ARB_HOLD_IF  = 3'd3,
    ARB_HOLD_MEM = 3'd4
  } arb_state_t;

  localparam logic [3:0] BUS_SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and MEM stage.
// MEM wins ties; completed results are held while the pipeline stalls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              if_ce,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stallreq,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stallreq,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  arb_state_t        state;
  logic [DATA_W-1:0] buf_if;
  logic [DATA_W-1:0] buf_mem;
  logic              stalled;
  logic              ack_if;
  logic              ack_mem;
  logic              done_if;
  logic              done_mem;

  assign stalled  = |stall;
  assign ack_if   = (state == ARB_GNT_IF) && bus_ack;
  assign ack_mem  = (state == ARB_GNT_MEM) && bus_ack;
  assign done_if  = ack_if || (state == ARB_HOLD_IF);
  assign done_mem = ack_mem || (state == ARB_HOLD_MEM);

  assign if_stallreq  = if_ce & ~done_if & ~flush;
  assign mem_stallreq = mem_ce & ~done_mem & ~flush;

  assign if_rdata  = ack_if ? bus_rdata : buf_if;
  assign mem_rdata = ack_mem ? bus_rdata : buf_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      buf_if    <= '0;
      buf_mem   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (flush) begin
            state <= ARB_IDLE;
          end else if (mem_ce) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_sel   <= mem_sel;
            bus_wdata <= mem_wdata;
            state     <= ARB_GNT_MEM;
          end else if (if_ce) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= if_addr;
            bus_sel  <= BUS_SEL_ALL;
            state    <= ARB_GNT_IF;
          end
        end
        ARB_GNT_IF: begin
          // A flush discards the access even if the ack lands this cycle.
          if (flush) begin
            bus_req <= 1'b0;
            state   <= ARB_IDLE;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            buf_if  <= bus_rdata;
            state   <= stalled ? ARB_HOLD_IF : ARB_IDLE;
          end
        end
        ARB_GNT_MEM: begin
          if (flush) begin
            bus_req <= 1'b0;
            state   <= ARB_IDLE;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            buf_mem <= bus_rdata;
            state   <= stalled ? ARB_HOLD_MEM : ARB_IDLE;
          end
        end
        ARB_HOLD_IF, ARB_HOLD_MEM: begin
          if (flush || !stalled) state <= ARB_IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stallreq;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_stallreq(if_stallreq),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0;
    if_ce = 1'b0; if_addr = '0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_addr = '0;
    mem_sel = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus_req !== 1'b0) begin
      fails++; $display("FAIL rst_req got=%0b exp=0", bus_req);
    end
    tests++;
    if (bus_addr !== 32'h0 || bus_sel !== 4'h0 || bus_we !== 1'b0) begin
      fails++;
      $display("FAIL rst_bus addr=%h sel=%h we=%b exp=0", bus_addr, bus_sel, bus_we);
    end
    tests++;
    if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_rdata if=%h mem=%h exp=0", if_rdata, mem_rdata);
    end
    // reset arriving mid-transfer
    rst = 1'b0;
    mem_ce = 1'b1; mem_addr = 32'h300; mem_sel = 4'hF;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin
      fails++;
      $display("FAIL rst_issue req=%b addr=%h exp=1/300", bus_req, bus_addr);
    end
    rst = 1'b1; mem_ce = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid req=%b addr=%h exp=0/0", bus_req, bus_addr);
    end
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b0 || mem_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_noack req=%b mem_rdata=%h exp=0/0", bus_req, mem_rdata);
    end
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_fetch();
    if_ce = 1'b1; if_addr = 32'h100;
    #1;
    tests++;
    if (if_stallreq !== 1'b1) begin
      fails++; $display("FAIL fetch_stall0 got=%b exp=1", if_stallreq);
    end
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h100 ||
        bus_we !== 1'b0 || bus_sel !== 4'hF) begin
      fails++;
      $display("FAIL fetch_bus req=%b addr=%h we=%b sel=%h exp=1/100/0/f",
               bus_req, bus_addr, bus_we, bus_sel);
    end
    bus_ack = 1'b1; bus_rdata = 32'h24010001;
    #1;
    tests++;
    if (if_stallreq !== 1'b0 || if_rdata !== 32'h24010001) begin
      fails++;
      $display("FAIL fetch_ack stall=%b rdata=%h exp=0/24010001", if_stallreq, if_rdata);
    end
    @(negedge clk);
    if_ce = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #1;
    tests++;
    if (bus_req !== 1'b0 || if_rdata !== 32'h24010001) begin
      fails++;
      $display("FAIL fetch_buf req=%b rdata=%h exp=0/24010001", bus_req, if_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_priority();
    if_ce = 1'b1; if_addr = 32'h140;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_sel = 4'hF;
    #1;
    tests++;
    if (if_stallreq !== 1'b1 || mem_stallreq !== 1'b1) begin
      fails++;
      $display("FAIL prio_req if=%b mem=%b exp=1/1", if_stallreq, mem_stallreq);
    end
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h200) begin
      fails++;
      $display("FAIL prio_first req=%b addr=%h exp=1/200", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    #1;
    tests++;
    if (mem_stallreq !== 1'b0 || if_stallreq !== 1'b1 ||
        mem_rdata !== 32'h11112222) begin
      fails++;
      $display("FAIL prio_mack mst=%b ist=%b rdata=%h exp=0/1/11112222",
               mem_stallreq, if_stallreq, mem_rdata);
    end
    @(negedge clk);
    mem_ce = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #1;
    tests++;
    if (bus_req !== 1'b0 || if_stallreq !== 1'b1) begin
      fails++;
      $display("FAIL prio_gap req=%b ist=%b exp=0/1", bus_req, if_stallreq);
    end
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h140 || bus_sel !== 4'hF) begin
      fails++;
      $display("FAIL prio_second req=%b addr=%h sel=%h exp=1/140/f",
               bus_req, bus_addr, bus_sel);
    end
    bus_ack = 1'b1; bus_rdata = 32'h33334444;
    #1;
    tests++;
    if (if_rdata !== 32'h33334444 || if_stallreq !== 1'b0) begin
      fails++;
      $display("FAIL prio_iack rdata=%h ist=%b exp=33334444/0", if_rdata, if_stallreq);
    end
    @(negedge clk);
    if_ce = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #1;
    tests++;
    if (mem_rdata !== 32'h11112222 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL prio_mbuf rdata=%h req=%b exp=11112222/0", mem_rdata, bus_req);
    end
    @(negedge clk);
  endtask

  task automatic test_store();
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h204;
    mem_sel = 4'b0011; mem_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) bus_ack = 1'b1;
      #1;
      tests++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h204 ||
          bus_sel !== 4'b0011 || bus_wdata !== 32'hDEADBEEF) begin
        fails++;
        $display("FAIL store_hold[%0d] req=%b we=%b addr=%h sel=%h wd=%h exp=1/1/204/3/deadbeef",
                 i, bus_req, bus_we, bus_addr, bus_sel, bus_wdata);
      end
      tests++;
      if (mem_stallreq !== (i != 3)) begin
        fails++;
        $display("FAIL store_stall[%0d] got=%b exp=%b", i, mem_stallreq, i != 3);
      end
    end
    @(negedge clk);
    mem_ce = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    #1;
    tests++;
    if (bus_req !== 1'b0) begin
      fails++; $display("FAIL store_done req=%b exp=0", bus_req);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    if_ce = 1'b1; if_addr = 32'h180;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; stall = 6'b000011;
    #1;
    tests++;
    if (if_rdata !== 32'hCAFEF00D) begin
      fails++; $display("FAIL hold_ack rdata=%h exp=cafef00d", if_rdata);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'hFFFFFFFF;
      #1;
      tests++;
      if (if_rdata !== 32'hCAFEF00D || if_stallreq !== 1'b0 || bus_req !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d] rdata=%h ist=%b req=%b exp=cafef00d/0/0",
                 i, if_rdata, if_stallreq, bus_req);
      end
    end
    @(negedge clk);
    stall = '0;
    #1;
    tests++;
    if (if_rdata !== 32'hCAFEF00D || if_stallreq !== 1'b0) begin
      fails++;
      $display("FAIL hold_rel rdata=%h ist=%b exp=cafef00d/0", if_rdata, if_stallreq);
    end
    @(negedge clk);
    #1;
    // back in IDLE: the still-asserted fetch is pending again
    tests++;
    if (if_stallreq !== 1'b1 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL hold_idle ist=%b req=%b exp=1/0", if_stallreq, bus_req);
    end
    if_ce = 1'b0; bus_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    if_ce = 1'b1; if_addr = 32'h1C0;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h1C0) begin
      fails++;
      $display("FAIL flush_issue req=%b addr=%h exp=1/1c0", bus_req, bus_addr);
    end
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h77777777;
    #1;
    tests++;
    if (if_stallreq !== 1'b0) begin
      fails++; $display("FAIL flush_stall got=%b exp=0", if_stallreq);
    end
    @(negedge clk);
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #1;
    tests++;
    if (bus_req !== 1'b0 || if_rdata !== 32'hCAFEF00D || if_stallreq !== 1'b1) begin
      fails++;
      $display("FAIL flush_after req=%b rdata=%h ist=%b exp=0/cafef00d/1",
               bus_req, if_rdata, if_stallreq);
    end
    if_ce = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_hold();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
